stim_request_scheduler: RTL and testbench

- Sequences the stimulation resource shared by the per-DAC window discriminators.
- Collects one-sample stim requests from up to `N_REQ` discriminator channels and grants them round-robin to a single stimulator.
- Generates the stim pulse, then a post-stim blanking interval (drives HPF hold / DAC noise suppression), then a refractory interval.
- Runs once per amplifier sample, beside the discriminator FSMs in the main sample loop.

---
 rtl/stim_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/stim_request_scheduler.sv | 156 +++++++++++++++
 tb/tb_stim_request_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_sched_pkg.sv
// Shared types and defaults for the stimulation request scheduler.
package stim_sched_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPulse   = 2'd1,
    StBlank   = 2'd2,
    StRefract = 2'd3
  } sched_state_e;

  localparam int unsigned NReqDefault = 8;
  localparam int unsigned CntWDefault = 16;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ChIdxWDefault = idx_width(NReqDefault);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of eff at or above rr_ptr, wrapping.
module rr_arbiter
  import stim_sched_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eff,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    idx          = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = IDX_W'((32'(rr_ptr) + off) % N_REQ);
      if (!grant_valid && eff[idx]) begin
        grant_valid       = 1'b1;
        grant_idx         = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stim_request_scheduler.sv
// Round-robin scheduler for a shared stimulator: pulse, blanking and refractory
// intervals per grant, with pending requests and a saturating drop counter.
module stim_request_scheduler
  import stim_sched_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic                          sample_CLK_out,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              stim_req,
  input  logic [N_REQ-1:0]              req_mask,
  input  logic [CNT_W-1:0]              pulse_width,
  input  logic [CNT_W-1:0]              blank_len,
  input  logic [CNT_W-1:0]              refractory_len,
  output logic                          stim_out,
  output logic [idx_width(N_REQ)-1:0]   stim_ch,
  output logic                          blank_out,
  output logic                          busy,
  output logic [CNT_W-1:0]              dropped_count
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  sched_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] blank_q;
  logic [CNT_W-1:0] refr_q;
  logic [N_REQ-1:0] pending_q;
  logic [IdxW-1:0]  rr_ptr_q;

  logic [N_REQ-1:0] eff;
  logic [N_REQ-1:0] arb_onehot;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_valid;
  logic             can_grant;
  logic             grant;
  logic [N_REQ-1:0] grant_onehot;
  logic [CNT_W-1:0] pulse_len;
  logic [IdxW-1:0]  rr_next;
  logic             drop_hit;

  assign eff = (stim_req | pending_q) & req_mask;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IdxW)
  ) u_rr_arbiter (
    .eff         (eff),
    .rr_ptr      (rr_ptr_q),
    .grant_onehot(arb_onehot),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign can_grant    = enable && (state_q == StIdle);
  assign grant        = can_grant && arb_valid;
  assign grant_onehot = can_grant ? arb_onehot : '0;
  assign pulse_len    = (pulse_width == '0) ? CNT_W'(1) : pulse_width;
  assign rr_next      = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + IdxW'(1);
  // A repeat request on a channel that is already waiting is lost.
  assign drop_hit     = |(stim_req & req_mask & pending_q & ~grant_onehot);

  always_ff @(posedge sample_CLK_out) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      blank_q   <= '0;
      refr_q    <= '0;
      stim_out  <= 1'b0;
      blank_out <= 1'b0;
      busy      <= 1'b0;
      stim_ch   <= '0;
      rr_ptr_q  <= '0;
    end else if (!enable) begin
      state_q   <= StIdle;
      stim_out  <= 1'b0;
      blank_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            state_q   <= StPulse;
            cnt_q     <= pulse_len;
            blank_q   <= blank_len;
            refr_q    <= refractory_len;
            stim_ch   <= arb_idx;
            rr_ptr_q  <= rr_next;
            stim_out  <= 1'b1;
            blank_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == CNT_W'(1)) begin
            stim_out <= 1'b0;
            if (blank_q != '0) begin
              state_q <= StBlank;
              cnt_q   <= blank_q;
            end else if (refr_q != '0) begin
              state_q   <= StRefract;
              cnt_q     <= refr_q;
              blank_out <= 1'b0;
            end else begin
              state_q   <= StIdle;
              blank_out <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StBlank: begin
          if (cnt_q == CNT_W'(1)) begin
            blank_out <= 1'b0;
            if (refr_q != '0) begin
              state_q <= StRefract;
              cnt_q   <= refr_q;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StRefract: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge sample_CLK_out) begin
    if (reset) begin
      pending_q     <= '0;
      dropped_count <= '0;
    end else if (!enable) begin
      pending_q <= '0;
    end else begin
      pending_q <= eff & ~grant_onehot;
      if (drop_hit && (dropped_count != '1)) begin
        dropped_count <= dropped_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stim_request_scheduler.sv
// Bench for stim_request_scheduler: directed scenarios plus random traffic
// against an interval-arithmetic reference model.
module tb_stim_request_scheduler;

  localparam int N       = 8;
  localparam int CW      = 5;
  localparam int DropMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  stim_req;
  logic [N-1:0]  req_mask;
  logic [CW-1:0] pulse_width;
  logic [CW-1:0] blank_len;
  logic [CW-1:0] refractory_len;
  logic          stim_out;
  logic [2:0]    stim_ch;
  logic          blank_out;
  logic          busy;
  logic [CW-1:0] dropped_count;

  stim_request_scheduler #(
    .N_REQ(N),
    .CNT_W(CW)
  ) dut (
    .sample_CLK_out(clk),
    .reset         (reset),
    .enable        (enable),
    .stim_req      (stim_req),
    .req_mask      (req_mask),
    .pulse_width   (pulse_width),
    .blank_len     (blank_len),
    .refractory_len(refractory_len),
    .stim_out      (stim_out),
    .stim_ch       (stim_ch),
    .blank_out     (blank_out),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a grant at edge gk occupies the stimulator for P+B+R edges.
  int       t = 0;
  bit       m_active = 0;
  int       gk = 0, mp = 0, mb = 0, mr = 0;
  logic [N-1:0] m_pend = '0;
  int       m_rr = 0, m_ch = 0, m_drop = 0;

  task automatic model_edge();
    logic [N-1:0] eff;
    logic [N-1:0] gbit;
    int g;
    if (reset) begin
      m_active = 0; m_pend = '0; m_rr = 0; m_ch = 0; m_drop = 0;
    end else if (!enable) begin
      m_active = 0; m_pend = '0;
    end else begin
      if (m_active && (t - gk) > mp + mb + mr) m_active = 0;
      eff  = (stim_req | m_pend) & req_mask;
      gbit = '0;
      g    = -1;
      if (!m_active) begin
        for (int off = 0; off < N; off++) begin
          if (g < 0 && eff[(m_rr + off) % N]) g = (m_rr + off) % N;
        end
      end
      if (g >= 0) gbit[g] = 1'b1;
      if (((stim_req & req_mask & m_pend & ~gbit) != '0) && m_drop < DropMax) m_drop++;
      m_pend = eff & ~gbit;
      if (g >= 0) begin
        m_active = 1;
        gk   = t;
        mp   = (pulse_width == '0) ? 1 : int'(pulse_width);
        mb   = int'(blank_len);
        mr   = int'(refractory_len);
        m_ch = g;
        m_rr = (g + 1) % N;
      end
    end
  endtask

  // Observation trackers for the directed scenarios.
  int   stim_hi, blank_hi, busy_hi;
  int   rises[$];
  int   grants[$];
  logic prev_stim = 1'b0;

  task automatic clear_obs();
    stim_hi = 0; blank_hi = 0; busy_hi = 0;
    rises.delete();
    grants.delete();
  endtask

  function automatic int g_at(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  task automatic cycle();
    int dt;
    model_edge();
    @(posedge clk);
    #1;
    dt = t - gk;
    check_eq("stim_out", 32'(stim_out), 32'(m_active && dt < mp));
    check_eq("blank_out", 32'(blank_out), 32'(m_active && dt < mp + mb));
    check_eq("busy", 32'(busy), 32'(m_active && dt < mp + mb + mr));
    check_eq("stim_ch", 32'(stim_ch), 32'(m_ch));
    check_eq("dropped_count", 32'(dropped_count), 32'(m_drop));
    if (stim_out) stim_hi++;
    if (blank_out) blank_hi++;
    if (busy) busy_hi++;
    if (stim_out && !prev_stim) begin
      rises.push_back(t);
      grants.push_back(int'(stim_ch));
    end
    prev_stim = stim_out;
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_req(input logic [N-1:0] r);
    stim_req = r;
    cycle();
    stim_req = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; stim_req = '0; req_mask = '1;
    pulse_width = '0; blank_len = '0; refractory_len = '0;
    clear_obs();
    run(2);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_drop", 32'(dropped_count), 0);

    // Single request on channel 2.
    reset = 1'b0; enable = 1'b1;
    pulse_width = 5'd3; blank_len = 5'd2; refractory_len = 5'd4;
    clear_obs();
    pulse_req(8'h04);
    run(12);
    check_eq("single_ch", 32'(g_at(0)), 2);
    check_eq("single_stim_len", 32'(stim_hi), 3);
    check_eq("single_blank_len", 32'(blank_hi), 5);
    check_eq("single_busy_len", 32'(busy_hi), 9);
    check_eq("single_drop", 32'(dropped_count), 0);

    // Round-robin from rr_ptr = 0.
    reset = 1'b1; cycle(); reset = 1'b0;
    clear_obs();
    pulse_req(8'h81);
    run(25);
    pulse_req(8'h81);
    run(25);
    check_eq("rr_count", 32'(grants.size()), 4);
    check_eq("rr_g0", 32'(g_at(0)), 0);
    check_eq("rr_g1", 32'(g_at(1)), 7);
    check_eq("rr_g2", 32'(g_at(2)), 0);
    check_eq("rr_g3", 32'(g_at(3)), 7);

    // Second request on an already pending channel is dropped.
    clear_obs();
    pulse_req(8'h01);
    pulse_req(8'h02);
    cycle();
    pulse_req(8'h02);
    run(25);
    check_eq("drop_count", 32'(dropped_count), 1);
    check_eq("drop_grants", 32'(grants.size()), 2);
    check_eq("drop_served", 32'(g_at(1)), 1);

    // Zero lengths: one-cycle pulses, back-to-back two samples apart.
    pulse_width = '0; blank_len = '0; refractory_len = '0;
    clear_obs();
    stim_req = 8'h08;
    run(4);
    stim_req = '0;
    run(6);
    check_eq("zero_pulses", 32'(rises.size()), 3);
    check_eq("zero_stim_cycles", 32'(stim_hi), 3);
    check_eq("zero_spacing", 32'((rises.size() > 1) ? rises[1] - rises[0] : -1), 2);
    check_eq("zero_drop", 32'(dropped_count), 1);

    // Masked request: no grant, no drop.
    clear_obs();
    req_mask = 8'hFE;
    pulse_req(8'h01);
    run(4);
    req_mask = 8'hFF;
    check_eq("mask_pulses", 32'(rises.size()), 0);
    check_eq("mask_drop", 32'(dropped_count), 1);

    // Enable low mid-pulse kills the pulse and clears pending.
    pulse_width = 5'd6; blank_len = 5'd2; refractory_len = 5'd2;
    clear_obs();
    pulse_req(8'h10);
    pulse_req(8'h20);
    cycle();
    enable = 1'b0;
    cycle();
    check_eq("en_stim_off", 32'(stim_out), 0);
    check_eq("en_busy_off", 32'(busy), 0);
    enable = 1'b1;
    run(20);
    check_eq("en_pulses", 32'(rises.size()), 1);
    check_eq("en_ch_hold", 32'(stim_ch), 4);

    // Reset during BLANK, then a fresh full sequence on channel 5.
    pulse_width = 5'd3; blank_len = 5'd4; refractory_len = 5'd2;
    pulse_req(8'h02);
    run(4);
    check_eq("rst_pre_blank", 32'(blank_out && !stim_out), 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_blank", 32'(blank_out), 0);
    check_eq("rst_ch", 32'(stim_ch), 0);
    clear_obs();
    pulse_req(8'h20);
    run(15);
    check_eq("rst_seq_ch", 32'(g_at(0)), 5);
    check_eq("rst_seq_stim", 32'(stim_hi), 3);
    check_eq("rst_seq_blank", 32'(blank_hi), 7);
    check_eq("rst_seq_busy", 32'(busy_hi), 9);

    // All-ones pulse length: no wrap-around.
    pulse_width = '1; blank_len = '0; refractory_len = '0;
    clear_obs();
    pulse_req(8'h01);
    run(35);
    check_eq("max_stim_len", 32'(stim_hi), DropMax);
    check_eq("max_busy_len", 32'(busy_hi), DropMax);

    // Random traffic; dense requests also push the drop counter into saturation.
    for (int i = 0; i < 1500; i++) begin
      if (i % 25 == 0) begin
        pulse_width    = CW'($urandom_range(0, 4));
        blank_len      = CW'($urandom_range(0, 3));
        refractory_len = CW'($urandom_range(0, 3));
      end
      reset    = ($urandom_range(0, 299) == 0);
      enable   = ($urandom_range(0, 39) != 0);
      req_mask = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
      stim_req = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
